id_ex_stage: RTL and testbench

ID/EX pipeline stage that sits directly upstream of the ALU. It registers decoded operands and control from the decode stage. It resolves data hazards by forwarding from EX/MEM and MEM/WB and by detecting load-use conflicts. Each cycle it presents the ALU with final `Ope1`, `Ope2` and the 3-bit `AluOp`.

---
 rtl/mips_defs.sv | 30 +++
 rtl/alu_control.sv | 33 +++
 rtl/id_ex_stage.sv | 141 ++++++++++++++
 tb/tb_id_ex_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS datapath encodings: ALU operation codes, main-control ALU classes
// and R-type funct values, used by the ID/EX stage and the ALU alike.
package mips_defs;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_NOR = 3'b100,
    ALU_XOR = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    MAIN_ADD   = 2'b00,
    MAIN_SUB   = 2'b01,
    MAIN_RTYPE = 2'b10,
    MAIN_OR    = 2'b11
  } alu_main_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU control: maps main-control class and funct to the ALU opcode.
// Unknown R-type functs fall back to ADD.
module alu_control
  import mips_defs::*;
(
  input  logic [1:0] alu_main,
  input  logic [5:0] funct,
  output logic [2:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (alu_main_e'(alu_main))
      MAIN_ADD: alu_op = ALU_ADD;
      MAIN_SUB: alu_op = ALU_SUB;
      MAIN_OR:  alu_op = ALU_OR;
      MAIN_RTYPE: begin
        case (funct)
          FUNCT_AND: alu_op = ALU_AND;
          FUNCT_OR:  alu_op = ALU_OR;
          FUNCT_ADD: alu_op = ALU_ADD;
          FUNCT_SUB: alu_op = ALU_SUB;
          FUNCT_SLT: alu_op = ALU_SLT;
          FUNCT_NOR: alu_op = ALU_NOR;
          FUNCT_XOR: alu_op = ALU_XOR;
          default:   alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB,
// load-use hazard detection and the ALU control decode feeding the ALU directly.
module id_ex_stage
  import mips_defs::*;
#(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [5:0]        id_funct,
  input  logic [1:0]        id_alu_main,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              stall,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] Ope1,
  output logic [DATA_W-1:0] Ope2,
  output logic [2:0]        AluOp,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_wreg,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              stall_req
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] imm;
    logic [5:0]        funct;
    logic [1:0]        alu_main;
    logic              alu_src;
    logic              reg_dst;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } id_ex_t;

  id_ex_t id_p0;
  id_ex_t ex_p1;

  // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is hardwired zero.
  function automatic logic [DATA_W-1:0] forward(
    input logic [REG_W-1:0]  idx,
    input logic [DATA_W-1:0] reg_val,
    input logic              em_we,
    input logic [REG_W-1:0]  em_rd,
    input logic [DATA_W-1:0] em_res,
    input logic              mw_we,
    input logic [REG_W-1:0]  mw_rd,
    input logic [DATA_W-1:0] mw_res
  );
    logic [DATA_W-1:0] val;
    val = reg_val;
    if (em_we && (em_rd != '0) && (em_rd == idx)) val = em_res;
    else if (mw_we && (mw_rd != '0) && (mw_rd == idx)) val = mw_res;
    return val;
  endfunction

  // ---- p0: decode-side capture bundle ----
  assign id_p0 = '{
    valid:      id_valid,
    rs_val:     id_rs_val,
    rt_val:     id_rt_val,
    rs:         id_rs,
    rt:         id_rt,
    rd:         id_rd,
    imm:        id_imm,
    funct:      id_funct,
    alu_main:   id_alu_main,
    alu_src:    id_alu_src,
    reg_dst:    id_reg_dst,
    reg_write:  id_reg_write,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    mem_to_reg: id_mem_to_reg
  };

  assign stall_req = !flush && ex_p1.valid && ex_p1.mem_read && (ex_p1.rt != '0) &&
                     ((ex_p1.rt == id_rs) || (ex_p1.rt == id_rt)) && id_valid;

  // ---- p1: ID/EX register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ex_p1 <= '0;
    else if (flush)     ex_p1 <= '0;
    else if (stall)     ex_p1 <= ex_p1;
    else if (stall_req) ex_p1 <= '0;
    else                ex_p1 <= id_p0;
  end

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  assign fwd_rs = forward(ex_p1.rs, ex_p1.rs_val, exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result);
  assign fwd_rt = forward(ex_p1.rt, ex_p1.rt_val, exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result);

  assign Ope1          = fwd_rs;
  assign Ope2          = ex_p1.alu_src ? ex_p1.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_wreg       = ex_p1.reg_dst ? ex_p1.rd : ex_p1.rt;
  assign ex_valid      = ex_p1.valid;
  assign ex_reg_write  = ex_p1.reg_write;
  assign ex_mem_read   = ex_p1.mem_read;
  assign ex_mem_write  = ex_p1.mem_write;
  assign ex_mem_to_reg = ex_p1.mem_to_reg;

  alu_control u_alu_control (
    .alu_main (ex_p1.alu_main),
    .funct    (ex_p1.funct),
    .alu_op   (AluOp)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected ALU-side outputs
// from a behavioural model; a negedge monitor pops and compares.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_alu_main;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] Ope1, Ope2, ex_store_data;
  logic [2:0]  AluOp;
  logic [4:0]  ex_wreg;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall_req;

  id_ex_stage #(.REG_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
    .id_funct(id_funct), .id_alu_main(id_alu_main),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .Ope1(Ope1), .Ope2(Ope2), .AluOp(AluOp), .ex_store_data(ex_store_data),
    .ex_wreg(ex_wreg), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit        valid;
    bit [31:0] rs_val, rt_val;
    bit [4:0]  rs, rt, rd;
    bit [31:0] imm;
    bit [5:0]  funct;
    bit [1:0]  alu_main;
    bit        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
    bit        stall, flush;
    bit        exw;
    bit [4:0]  exrd;
    bit [31:0] exres;
    bit        mww;
    bit [4:0]  mwrd;
    bit [31:0] mwres;
  } stim_t;

  typedef struct packed {
    bit [31:0] ope1, ope2, store;
    bit [2:0]  aluop;
    bit [4:0]  wreg;
    bit        valid, rw, mr, mw, m2r, sreq;
  } exp_t;

  exp_t  q[$];
  stim_t m;            // instruction the model believes sits in EX
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  bit [2:0] rtype_op [bit [5:0]];
  bit [2:0] main_op [4] = '{3'b010, 3'b110, 3'b010, 3'b001};
  bit [5:0] funct_pool [8] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010,
                               6'b101010, 6'b100111, 6'b100110, 6'b000000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] ref_operand(input bit [4:0] idx, input bit [31:0] regv,
                                             input stim_t s);
    if (s.exw && s.exrd != 0 && s.exrd == idx) return s.exres;
    if (s.mww && s.mwrd != 0 && s.mwrd == idx) return s.mwres;
    return regv;
  endfunction

  function automatic bit [2:0] ref_aluop(input bit [1:0] cls, input bit [5:0] f);
    if (cls != 2'b10) return main_op[cls];
    if (rtype_op.exists(f)) return rtype_op[f];
    return 3'b010;
  endfunction

  function automatic exp_t model_out(input stim_t s);
    exp_t e;
    e.ope1  = ref_operand(m.rs, m.rs_val, s);
    e.store = ref_operand(m.rt, m.rt_val, s);
    e.ope2  = m.alu_src ? m.imm : e.store;
    e.aluop = ref_aluop(m.alu_main, m.funct);
    e.wreg  = m.reg_dst ? m.rd : m.rt;
    e.valid = m.valid;
    e.rw    = m.reg_write;
    e.mr    = m.mem_read;
    e.mw    = m.mem_write;
    e.m2r   = m.mem_to_reg;
    e.sreq  = !s.flush && m.valid && m.mem_read && m.rt != 0 &&
              (m.rt == s.rs || m.rt == s.rt) && s.valid;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    id_valid = s.valid; id_rs_val = s.rs_val; id_rt_val = s.rt_val;
    id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; id_imm = s.imm;
    id_funct = s.funct; id_alu_main = s.alu_main; id_alu_src = s.alu_src;
    id_reg_dst = s.reg_dst; id_reg_write = s.reg_write; id_mem_read = s.mem_read;
    id_mem_write = s.mem_write; id_mem_to_reg = s.mem_to_reg;
    stall = s.stall; flush = s.flush;
    exmem_reg_write = s.exw; exmem_rd = s.exrd; exmem_result = s.exres;
    memwb_reg_write = s.mww; memwb_rd = s.mwrd; memwb_result = s.mwres;
  endtask

  // Called just after a rising edge: drive, predict this cycle, then advance the model.
  task automatic apply(input stim_t s);
    exp_t e;
    drive(s);
    e = model_out(s);
    q.push_back(e);
    @(posedge clk);
    if (s.flush)       m = '0;
    else if (s.stall)  m = m;
    else if (e.sreq)   m = '0;
    else               m = s;
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cyc++;
      chk($sformatf("c%0d Ope1", cyc), Ope1, e.ope1);
      chk($sformatf("c%0d Ope2", cyc), Ope2, e.ope2);
      chk($sformatf("c%0d AluOp", cyc), {29'd0, AluOp}, {29'd0, e.aluop});
      chk($sformatf("c%0d store", cyc), ex_store_data, e.store);
      chk($sformatf("c%0d wreg", cyc), {27'd0, ex_wreg}, {27'd0, e.wreg});
      chk($sformatf("c%0d valid", cyc), {31'd0, ex_valid}, {31'd0, e.valid});
      chk($sformatf("c%0d reg_write", cyc), {31'd0, ex_reg_write}, {31'd0, e.rw});
      chk($sformatf("c%0d mem_read", cyc), {31'd0, ex_mem_read}, {31'd0, e.mr});
      chk($sformatf("c%0d mem_write", cyc), {31'd0, ex_mem_write}, {31'd0, e.mw});
      chk($sformatf("c%0d mem_to_reg", cyc), {31'd0, ex_mem_to_reg}, {31'd0, e.m2r});
      chk($sformatf("c%0d stall_req", cyc), {31'd0, stall_req}, {31'd0, e.sreq});
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, " ex_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, " ex_reg_write"}, {31'd0, ex_reg_write}, 32'd0);
    chk({tag, " ex_mem_read"}, {31'd0, ex_mem_read}, 32'd0);
    chk({tag, " ex_mem_write"}, {31'd0, ex_mem_write}, 32'd0);
    chk({tag, " AluOp"}, {29'd0, AluOp}, 32'h2);
    chk({tag, " Ope1"}, Ope1, 32'd0);
    chk({tag, " stall_req"}, {31'd0, stall_req}, 32'd0);
  endtask

  // Reset asserted between edges, checked before the next edge, released off-edge.
  task automatic mid_reset(input string tag);
    drive('0);
    #2 rst_n = 1'b0;
    #1 reset_checks(tag);
    #3 rst_n = 1'b1;
    @(posedge clk);
    m = '0;
    #1;
  endtask

  function automatic stim_t rtype(input bit [4:0] rs, input bit [31:0] rsv,
                                  input bit [4:0] rt, input bit [31:0] rtv,
                                  input bit [4:0] rd, input bit [5:0] f);
    stim_t s = '0;
    s.valid = 1; s.rs = rs; s.rs_val = rsv; s.rt = rt; s.rt_val = rtv; s.rd = rd;
    s.funct = f; s.alu_main = 2'b10; s.reg_dst = 1; s.reg_write = 1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid = ($urandom_range(3) != 0);
    s.rs_val = $urandom; s.rt_val = $urandom;
    s.rs = 5'($urandom_range(7)); s.rt = 5'($urandom_range(7)); s.rd = 5'($urandom_range(31));
    s.imm = $urandom;
    s.funct = ($urandom_range(1) == 1) ? funct_pool[$urandom_range(7)] : 6'($urandom);
    s.alu_main = 2'($urandom);
    s.alu_src = 1'($urandom); s.reg_dst = 1'($urandom); s.reg_write = 1'($urandom);
    s.mem_read = ($urandom_range(2) == 0); s.mem_write = 1'($urandom);
    s.mem_to_reg = 1'($urandom);
    s.stall = ($urandom_range(7) == 0); s.flush = ($urandom_range(11) == 0);
    s.exw = 1'($urandom); s.exrd = 5'($urandom_range(7)); s.exres = $urandom;
    s.mww = 1'($urandom); s.mwrd = 5'($urandom_range(7)); s.mwres = $urandom;
    return s;
  endfunction

  initial begin
    stim_t s, t;
    rtype_op[6'b100100] = 3'b000; rtype_op[6'b100101] = 3'b001;
    rtype_op[6'b100000] = 3'b010; rtype_op[6'b100010] = 3'b110;
    rtype_op[6'b101010] = 3'b111; rtype_op[6'b100111] = 3'b100;
    rtype_op[6'b100110] = 3'b101;
    m = '0;
    rst_n = 1'b0;
    drive('0);
    #3 reset_checks("por");
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Capture an add, then observe it; then reset mid-cycle with it in EX.
    apply(rtype(5'd3, 32'd5, 5'd4, 32'd7, 5'd5, 6'b100000));
    apply('0);
    apply(rtype(5'd3, 32'd5, 5'd4, 32'd7, 5'd5, 6'b100000));
    mid_reset("midrst");
    apply('0);

    // Forward priority and r0 exclusion, holding EX with stall.
    apply(rtype(5'd8, 32'h99, 5'd9, 32'h98, 5'd1, 6'b100000));
    s = '0; s.stall = 1; s.exw = 1; s.exrd = 5'd8; s.exres = 32'h11;
    s.mww = 1; s.mwrd = 5'd8; s.mwres = 32'h22;
    apply(s);
    s.exw = 0;
    apply(s);
    apply(rtype(5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 6'b100000));
    s = '0; s.stall = 1; s.exw = 1; s.exrd = 5'd0; s.exres = 32'h11;
    s.mww = 1; s.mwrd = 5'd0; s.mwres = 32'h22;
    apply(s);

    // Load-use: lw r2 in EX, consumer reads r2.
    s = '0; s.valid = 1; s.rs = 5'd1; s.rt = 5'd2; s.imm = 32'd4; s.alu_src = 1;
    s.mem_read = 1; s.mem_to_reg = 1; s.reg_write = 1;
    apply(s);
    t = rtype(5'd2, 32'h10, 5'd9, 32'h20, 5'd6, 6'b100010);
    apply(t);
    apply(t);
    apply('0);

    // Flush wins over stall; then stall alone for three cycles.
    apply(rtype(5'd5, 32'h1234, 5'd6, 32'h5678, 5'd7, 6'b100101));
    t = rtype(5'd1, 32'h1, 5'd1, 32'h1, 5'd1, 6'b100000);
    t.flush = 1; t.stall = 1;
    apply(t);
    apply(rtype(5'd5, 32'h1234, 5'd6, 32'h5678, 5'd7, 6'b101010));
    for (int i = 0; i < 3; i++) begin
      t = rand_stim(); t.stall = 1; t.flush = 0; t.exw = 0; t.mww = 0;
      apply(t);
    end
    apply('0);

    // AluOp sweep across every funct and main class.
    for (int i = 0; i < 8; i++) apply(rtype(5'd1, 32'd1, 5'd2, 32'd2, 5'd3, funct_pool[i]));
    for (int c = 0; c < 4; c++) begin
      s = '0; s.valid = 1; s.alu_main = 2'(c); s.funct = 6'b100010;
      apply(s);
    end
    apply('0);

    // Immediate path with rt forwarded for the store.
    s = '0; s.valid = 1; s.rs = 5'd1; s.rt = 5'd6; s.rt_val = 32'h77;
    s.imm = 32'hFFFFFFFC; s.alu_src = 1; s.mem_write = 1;
    apply(s);
    s = '0; s.stall = 1; s.exw = 1; s.exrd = 5'd6; s.exres = 32'h55;
    apply(s);
    apply('0);

    for (int i = 0; i < 400; i++) apply(rand_stim());
    apply('0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left unchecked", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
